mf_clkgen_frac: RTL
===================

Name: mf_clkgen_frac

Overview:
- Parametrised fractional clock-enable generator running on one PLL output clock.
- Produces NUM_CH independent single-cycle clock-enable pulse trains at arbitrary fractional rates (phase-accumulator carry), with a settle-gated locked flag.
- Supports glitch-free runtime retune through a valid/ready config port, and a common phase-realign strobe.
- Sits directly downstream of the core PLL and feeds CPU/VIA/audio/vector-timing enables.

Parameters:
NUM_CH, 4, number of enable channels (1..16)
ACC_W, 24, accumulator width; rate = inc / 2^ACC_W of refclk
LOCK_CYCLES, 1024, refclk cycles after reset release before locked asserts (>=1)
DEFAULT_INC, 0, reset increment for every channel (ACC_W bits)

Ports:
refclk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config slot free
cfg_ch  in  4  target channel
cfg_inc  in  ACC_W  new increment
cfg_phase  in  ACC_W  new phase offset, applied on sync
sync_req  in  1  one-cycle strobe: realign all accumulators
ce_out  out  NUM_CH  per-channel enable pulses
clk_sq  out  NUM_CH  per-channel square wave (optional feature)
locked  out  1  settle complete

Behaviour:
- Reset (async assert, sync to refclk on release): acc=0, inc=DEFAULT_INC, phase=0, lock counter=0, pending cleared; ce_out=0, clk_sq=0, locked=0, cfg_ready=1.
- Lock FSM, states SETTLE -> RUN. SETTLE counts refclk edges; locked goes 1 on the LOCK_CYCLES-th edge after reset release. The FSM then stays in RUN until rst.
- In SETTLE: accumulators held at 0; ce_out held 0.
- RUN, each edge per channel: {c, acc} <= acc + inc (ACC_W+1 bit add); ce_out[i] <= c. The pulse is one cycle wide, registered, and there is no combinational path.
- inc=0 stops the channel: no pulses, acc frozen.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready. It captures {ch, inc, phase} into a single pending slot; cfg_ready drops the next cycle.
- Pending slot is applied on the first of three events:
  - (a) an edge where the target channel carries; the new inc is used from the following add and the carry pulse is still emitted;
  - (b) the target channel's current inc==0, applied on the next edge;
  - (c) sync_req.
- cfg_ready returns to 1 on the cycle after the slot is applied.
- cfg_ch >= NUM_CH: the transfer is accepted and discarded; cfg_ready stays 1.
- Transfers are accepted during SETTLE. An apply in SETTLE takes effect immediately, since acc is held.
- sync_req in RUN: every acc <= its phase register; ce_out forced 0 that cycle. Accumulation resumes on the next edge.
- sync_req and a pending apply in the same cycle: inc and phase are written first, then acc loads the new phase.
- sync_req in SETTLE: ignored.
- rst mid-operation discards the pending slot and returns to SETTLE.

Optional Feature:
Macro MF_CLKGEN_SQUARE_EN.
- Defined: clk_sq[i] = registered MSB of acc[i], giving an approximately 50% duty square at the channel rate. It is 0 in SETTLE and follows acc after sync.
- Undefined: clk_sq is tied to 0 and no extra flops are generated.

Decomposition:
- Shared package mf_clkgen_pkg holds:
  - lock FSM state enum (SETTLE, RUN);
  - cfg request struct {ch, inc, phase};
  - max-channel constant 16.
- One sub-module, mf_clkgen_acc: a single-channel accumulator holding inc/phase registers, the carry pulse and the square output. The top instantiates NUM_CH of these via generate and owns the lock FSM and config slot.

Test Plan:
- Lock timing: LOCK_CYCLES=16, rst pulse -> locked=0 for 15 edges after release, 1 on the 16th; ce_out all 0 until then, even with DEFAULT_INC=0x400000.
- Integer divide: ACC_W=16, ch0 inc=0x4000 -> ce_out[0] high exactly every 4th cycle; 1000 cycles give 250 pulses.
- Fractional: ch1 inc=0x6000 -> exactly 3 pulses per 8 cycles, pulse spacing pattern 3,3,2 repeating.
- Glitch-free retune: ch0 at 0x4000, write inc=0x8000 mid-period -> cfg_ready low; at the next ch0 pulse the old period of 4 completes, after which the period becomes 2 and cfg_ready returns to 1.
- Sync and collision: phase ch0=0xC000, ch1=0; sync_req in the same cycle as a pending write -> ce_out=0 that cycle, ch0 pulses 1 cycle later, ch1 per its new inc; cfg_ch=9 with NUM_CH=4 is dropped and cfg_ready stays 1.
- Reset mid-run with pending config -> all outputs 0 immediately (async), pending lost, cfg_ready=1, relock after LOCK_CYCLES.

Source files
------------

// File: rtl/mf_clkgen_pkg.sv
// Shared types for the fractional clock-enable generator: lock FSM states,
// the configuration request record and channel-count limits.
package mf_clkgen_pkg;

  localparam int MAX_CH    = 16;
  localparam int CH_W      = 4;
  localparam int MAX_ACC_W = 32;

  typedef enum logic {
    SETTLE,
    RUN
  } lock_state_t;

  // Widths are fixed at the maximum; narrower builds zero-extend into it.
  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [MAX_ACC_W-1:0] inc;
    logic [MAX_ACC_W-1:0] phase;
  } cfg_req_t;

endpackage

// File: rtl/mf_clkgen_frac_if.sv
// Configuration port of mf_clkgen_frac: one valid/ready transfer carries
// a target channel, a new increment and a new phase offset.
interface mf_clkgen_frac_if
  import mf_clkgen_pkg::*;
#(
  parameter int ACC_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_phase, output cfg_ready);
endinterface

// File: rtl/mf_clkgen_acc.sv
// One phase-accumulator channel: inc/phase registers, registered carry pulse and
// the square output, which exists only when MF_CLKGEN_SQUARE_EN is defined.
module mf_clkgen_acc #(
  parameter int               ACC_W       = 24,
  parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  output logic             carry,
  output logic             inc_zero,
  output logic             ce,
  output logic             sq
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;
  logic             ce_next;

  assign sum      = {1'b0, acc} + {1'b0, inc};
  assign carry    = sum[ACC_W];
  assign inc_zero = (inc == '0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave a value held and infer a latch.
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    ce_next  = carry;
    if (!run) begin
      acc_next = '0;
      ce_next  = 1'b0;
    end else if (sync) begin
      // A config applied on the same edge must land before the realign.
      acc_next = wr ? wr_phase : phase;
      ce_next  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      inc   <= DEFAULT_INC;
      phase <= '0;
      ce    <= 1'b0;
    end else begin
      acc <= acc_next;
      ce  <= ce_next;
      if (wr) begin
        inc   <= wr_inc;
        phase <= wr_phase;
      end
    end
  end

`ifdef MF_CLKGEN_SQUARE_EN
  logic sq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sq_q <= 1'b0;
    else     sq_q <= acc_next[ACC_W-1];
  end

  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/mf_clkgen_frac.sv
// Fractional clock-enable generator: NUM_CH accumulator channels, settle-gated
// lock FSM and a single pending config slot. Square outputs: MF_CLKGEN_SQUARE_EN.
module mf_clkgen_frac
  import mf_clkgen_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               ACC_W       = 24,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
  input  logic                refclk,
  input  logic                rst,
  mf_clkgen_frac_if.slave     cfg,
  input  logic                sync_req,
  output logic [NUM_CH-1:0]   ce_out,
  output logic [NUM_CH-1:0]   clk_sq,
  output logic                locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(NUM_CH);

  lock_state_t       state;
  logic [CNT_W-1:0]  lock_cnt;
  logic              pend_valid;
  cfg_req_t          pend;

  logic              run;
  logic              sync_run;
  logic              apply;
  logic              accept;
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] inc_zero;
  logic [MAX_CH-1:0] carry_ext;
  logic [MAX_CH-1:0] zero_ext;
  logic              unused_pend_hi;

  assign run       = (state == RUN);
  assign sync_run  = sync_req & run;
  assign carry_ext = MAX_CH'(carry);
  assign zero_ext  = MAX_CH'(inc_zero);

  // While settling the accumulators are parked at 0, so any apply is safe.
  assign apply  = pend_valid & (~run | sync_req | carry_ext[pend.ch] | zero_ext[pend.ch]);
  assign accept = cfg.cfg_valid & ~pend_valid & ({1'b0, cfg.cfg_ch} < CH_LIMIT);
  assign cfg.cfg_ready = ~pend_valid;

  // Bits of the request record above ACC_W are constant zero.
  assign unused_pend_hi = ^{pend.inc >> ACC_W, pend.phase >> ACC_W};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= SETTLE;
      lock_cnt   <= '0;
      locked     <= 1'b0;
      pend_valid <= 1'b0;
      pend       <= '0;
    end else begin
      unique case (state)
        SETTLE: begin
          if (lock_cnt == LOCK_LAST) begin
            state  <= RUN;
            locked <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RUN: ;
      endcase

      if (apply) begin
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_valid <= 1'b1;
        pend       <= '{ch:    cfg.cfg_ch,
                        inc:   MAX_ACC_W'(cfg.cfg_inc),
                        phase: MAX_ACC_W'(cfg.cfg_phase)};
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mf_clkgen_acc #(
      .ACC_W      (ACC_W),
      .DEFAULT_INC(DEFAULT_INC)
    ) u_acc (
      .clk     (refclk),
      .rst     (rst),
      .run     (run),
      .sync    (sync_run),
      .wr      (apply && (pend.ch == CH_W'(i))),
      .wr_inc  (ACC_W'(pend.inc)),
      .wr_phase(ACC_W'(pend.phase)),
      .carry   (carry[i]),
      .inc_zero(inc_zero[i]),
      .ce      (ce_out[i]),
      .sq      (clk_sq[i])
    );
  end

endmodule
